// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
//
// Decodes fixed six-byte frames from a byte stream delivered by an upstream
// UART receiver:  0xF5, payload[31:24], payload[23:16], payload[15:8],
// payload[7:0], 0xFA.  Payload bytes are plain data (no escaping).  A frame
// that ends in a wrong byte, or stalls for TIMEOUT_CYCLES clocks, is aborted
// and counted.
//
// Parameters
//   CLK_FREQ        system clock in Hz (informational only)
//   TIMEOUT_CYCLES  inter-byte timeout in clk cycles (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_data     received byte
//   rx_valid    one-cycle strobe qualifying rx_data
//   word        last successfully decoded payload (held between frames)
//   word_valid  one-cycle strobe: word was just updated
//   frame_err   one-cycle strobe: a frame was aborted
//   err_count   saturating count of aborted frames
//   busy        high whenever a frame is in progress
// -----------------------------------------------------------------------------
module uart_frame_rx #(
   parameter int CLK_FREQ       = 25000000,
   parameter int TIMEOUT_CYCLES = 250000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [31:0] word,
   output logic        word_valid,
   output logic        frame_err,
   output logic [7:0]  err_count,
   output logic        busy
);

   localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TMO_RELOAD = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]  TMO_LAST   = TW'(1);
   localparam logic [7:0]     SOF        = 8'hF5;
   localparam logic [7:0]     EOF        = 8'hFA;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_t;

   // Reject nonsensical parameterisations at elaboration time.
   if (TIMEOUT_CYCLES < 1 || CLK_FREQ < 1) begin : g_bad_param
      $error("uart_frame_rx: TIMEOUT_CYCLES and CLK_FREQ must be >= 1");
   end

   state_t        state;
   logic [1:0]    byte_cnt;
   logic [31:0]   shreg;
   logic [TW-1:0] tmo;

   logic [7:0] err_next;
   logic       tmo_expire;

   assign err_next   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
   // The counter holds 1 on the last cycle before it would reach zero; a
   // cycle without a byte at that point is the expiry.  A byte arriving in
   // that same cycle takes the rx_valid branch first and therefore wins.
   assign tmo_expire = (tmo == TMO_LAST);

   // Decode of registered state only; rx_valid has no path to busy.
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         byte_cnt   <= 2'd0;
         shreg      <= 32'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         err_count  <= 8'd0;
         tmo        <= TMO_RELOAD;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // reads the pre-edge values of state, shreg and the counters.
         word_valid <= 1'b0;
         frame_err  <= 1'b0;

         case (state)
            IDLE: begin
               if (rx_valid && rx_data == SOF) begin
                  state    <= DATA;
                  byte_cnt <= 2'd0;
                  tmo      <= TMO_RELOAD;
               end
            end

            DATA: begin
               if (rx_valid) begin
                  shreg    <= {shreg[23:0], rx_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  tmo      <= TMO_RELOAD;
                  if (byte_cnt == 2'd3) begin
                     state <= TAIL;
                  end
               end else if (tmo_expire) begin
                  frame_err <= 1'b1;
                  err_count <= err_next;
                  state     <= IDLE;
                  tmo       <= TMO_RELOAD;
               end else begin
                  tmo <= tmo - TMO_LAST;
               end
            end

            TAIL: begin
               if (rx_valid) begin
                  tmo <= TMO_RELOAD;
                  if (rx_data == EOF) begin
                     word       <= shreg;
                     word_valid <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     err_count <= err_next;
                     // A stray start byte in the tail slot begins a new frame.
                     if (rx_data == SOF) begin
                        state    <= DATA;
                        byte_cnt <= 2'd0;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end else if (tmo_expire) begin
                  frame_err <= 1'b1;
                  err_count <= err_next;
                  state     <= IDLE;
                  tmo       <= TMO_RELOAD;
               end else begin
                  tmo <= tmo - TMO_LAST;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_rx
//
// Self-checking bench for uart_frame_rx (TIMEOUT_CYCLES = 16).  A frame-level
// reference model tracks the payload bytes collected since the last start
// byte and the number of idle cycles, and predicts all outputs after every
// rising edge; a compare process checks them on every falling edge.  Directed
// scenarios add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_uart_frame_rx;

   localparam int TMO = 16;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [31:0] word;
   logic        word_valid;
   logic        frame_err;
   logic [7:0]  err_count;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   uart_frame_rx #(
      .CLK_FREQ      (25000000),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .word      (word),
      .word_valid(word_valid),
      .frame_err (frame_err),
      .err_count (err_count),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   logic [7:0]  m_payload[$];
   bit          m_in_frame;
   int          m_idle;
   logic [31:0] m_word;
   bit          m_wv;
   bit          m_fe;
   int          m_err;

   function automatic void m_abort();
      m_fe = 1'b1;
      if (m_err < 255) m_err++;
      m_in_frame = 1'b0;
      m_payload.delete();
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_payload.delete();
         m_in_frame = 1'b0;
         m_idle     = 0;
         m_word     = 32'd0;
         m_wv       = 1'b0;
         m_fe       = 1'b0;
         m_err      = 0;
      end else begin
         m_wv = 1'b0;
         m_fe = 1'b0;
         if (!m_in_frame) begin
            if (rx_valid && rx_data == 8'hF5) begin
               m_in_frame = 1'b1;
               m_idle     = 0;
               m_payload.delete();
            end
         end else if (rx_valid) begin
            m_idle = 0;
            if (m_payload.size() < 4) begin
               m_payload.push_back(rx_data);
            end else if (rx_data == 8'hFA) begin
               m_word     = {m_payload[0], m_payload[1], m_payload[2], m_payload[3]};
               m_wv       = 1'b1;
               m_in_frame = 1'b0;
               m_payload.delete();
            end else begin
               m_abort();
               if (rx_data == 8'hF5) m_in_frame = 1'b1;
            end
         end else begin
            m_idle++;
            if (m_idle == TMO) m_abort();
         end
      end
   end

   // Compare process: outputs are settled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check("word",       word,       m_word);
         check("word_valid", word_valid, 32'(m_wv));
         check("frame_err",  frame_err,  32'(m_fe));
         check("err_count",  err_count,  32'(m_err));
         check("busy",       busy,       32'(m_in_frame));
      end
   end

   // ------------------------------------------------------------- stimulus
   // Called on a falling edge; returns on the falling edge after the byte
   // was sampled (plus gap idle cycles).
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] p);
      send_byte(8'hF5, 0);
      send_byte(p[31:24], 0);
      send_byte(p[23:16], 0);
      send_byte(p[15:8], 0);
      send_byte(p[7:0], 0);
      send_byte(8'hFA, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_word"}, word, 32'd0);
      check({tag, "_wv"},   word_valid, 32'd0);
      check({tag, "_fe"},   frame_err, 32'd0);
      check({tag, "_err"},  err_count, 32'd0);
      check({tag, "_busy"}, busy, 32'd0);
   endtask

   initial begin
      logic [7:0] seq2[8];
      logic [7:0] seq3b[11];

      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Basic frame, zero-gap, latency of one cycle after the FA strobe.
      send_frame(32'hDEADBEEF);
      check("s1_wv",   word_valid, 32'd1);
      check("s1_word", word, 32'hDEADBEEF);
      @(negedge clk);
      check("s1_wv_drop", word_valid, 32'd0);
      check("s1_busy",    busy, 32'd0);
      check("s1_err",     err_count, 32'd0);

      // Leading garbage ignored, spaced bytes.
      seq2 = '{8'h00, 8'h11, 8'hF5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFA};
      foreach (seq2[i]) send_byte(seq2[i], 1);
      check("s2_word", word, 32'h12345678);
      check("s2_err",  err_count, 32'd0);

      // Bad tail byte, then a tail-slot F5 that restarts a frame.
      send_byte(8'hF5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      check("s3_fe",   frame_err, 32'd1);
      check("s3_err",  err_count, 32'd1);
      check("s3_word", word, 32'h12345678);
      @(negedge clk);
      seq3b = '{8'hF5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5,
                8'h05, 8'h06, 8'h07, 8'h08, 8'hFA};
      foreach (seq3b[i]) begin
         send_byte(seq3b[i], 0);
         if (i == 5) begin
            check("s3_restart_fe",   frame_err, 32'd1);
            check("s3_restart_busy", busy, 32'd1);
            check("s3_restart_err",  err_count, 32'd2);
         end
      end
      check("s3_word2", word, 32'h05060708);
      check("s3_err2",  err_count, 32'd2);

      // A byte in the last cycle before expiry wins.
      send_byte(8'hF5, 0);
      send_byte(8'h01, TMO - 1);
      check("s4_nearly_busy", busy, 32'd1);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      send_byte(8'hFA, 0);
      check("s4_win_word", word, 32'h01020304);
      check("s4_win_err",  err_count, 32'd2);

      // Timeout after F5 01 02 and TMO idle cycles.
      send_byte(8'hF5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, TMO - 1);
      check("s4_pre_fe",   frame_err, 32'd0);
      check("s4_pre_busy", busy, 32'd1);
      @(negedge clk);
      check("s4_to_fe",   frame_err, 32'd1);
      check("s4_to_busy", busy, 32'd0);
      check("s4_to_err",  err_count, 32'd3);
      check("s4_to_word", word, 32'h01020304);
      send_frame(32'hCAFEBABE);
      check("s4_after_word", word, 32'hCAFEBABE);

      // Delimiter values as payload.
      send_frame(32'hFAF5FAF5);
      check("s5_word", word, 32'hFAF5FAF5);
      check("s5_err",  err_count, 32'd3);

      // Error burst saturates the counter.
      for (int f = 0; f < 300; f++) begin
         send_byte(8'hF5, 0);
         repeat (5) send_byte(8'h00, 0);
      end
      check("s5_sat_err",  err_count, 32'd255);
      check("s5_sat_word", word, 32'hFAF5FAF5);

      // Reset mid-frame: asynchronous clear, no frame_err.
      send_byte(8'hF5, 0);
      send_byte(8'hAA, 0);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("s6_rst");
      @(negedge clk);
      check_all_zero("s6_rst_hold");
      rst_n = 1'b1;
      send_frame(32'h00000001);
      check("s6_word", word, 32'h00000001);
      check("s6_err",  err_count, 32'd0);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net: the directed sequence is bounded, but never hang.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25000000, system clock frequency in Hz (documentation only; no functional effect).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 250000, the inter-byte timeout in clk cycles; legal range >= 1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx_data, input, 8, received byte from the upstream UART receiver.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port word, output, 32, last successfully decoded payload.
REQ-008 SHALL have port word_valid, output, 1, one-cycle strobe: word updated.
REQ-009 SHALL have port frame_err, output, 1, one-cycle strobe: frame aborted.
REQ-010 SHALL have port err_count, output, 8, saturating count of aborted frames.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-012 SHALL decode frames of exactly six bytes: 0xF5, payload MSB-first (4 bytes), 0xFA.
REQ-013 SHALL implement states IDLE, DATA and TAIL, plus a 2-bit payload byte counter.
REQ-014 In IDLE, on rx_valid with rx_data = 0xF5, SHALL go to DATA with counter = 0.
REQ-015 In IDLE, SHALL silently ignore any other byte, with no error and no count.
REQ-016 In DATA, each rx_valid SHALL shift rx_data into a 32-bit shift register (shreg = {shreg[23:0], rx_data}) and increment the counter.
REQ-017 SHALL go to TAIL on the 4th payload byte (counter wraps 3 -> 0).
REQ-018 Payload bytes equal to 0xF5 or 0xFA SHALL be treated as plain data (no escaping).
REQ-019 In TAIL, on rx_data = 0xFA, SHALL register word <= shreg, pulse word_valid for exactly one cycle, and return to IDLE.
REQ-020 Latency: word and word_valid SHALL be valid in the cycle immediately following the rx_valid cycle that carries 0xFA.
REQ-021 In TAIL, on any byte other than 0xFA: SHALL pulse frame_err and increment err_count.
REQ-022 That error byte, if 0xF5, SHALL restart a new frame (DATA, counter = 0); otherwise the state SHALL return to IDLE.
REQ-023 A timeout counter SHALL reload to TIMEOUT_CYCLES on entry to DATA and on every accepted byte in DATA or TAIL.
REQ-024 The timeout counter SHALL decrement on every cycle in DATA or TAIL without rx_valid; it is idle (no decrement) in IDLE.
REQ-025 On timeout expiry (counter reaches 0 without a byte): SHALL pulse frame_err, increment err_count, and return to IDLE; the partial payload is discarded.
REQ-026 If rx_valid arrives in the same cycle the timeout would expire, the byte SHALL win and no timeout SHALL occur.
REQ-027 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1) bits.
REQ-028 err_count SHALL saturate at 255 and never wrap.
REQ-029 word SHALL hold its value between successful frames; aborted frames SHALL never modify it.
REQ-030 word_valid and frame_err SHALL never be asserted in the same cycle.
REQ-031 busy SHALL be a registered-state decode (state != IDLE), with no combinational path from rx_valid.

Reset
REQ-032 While rst_n = 0, asynchronously and regardless of clk: state = IDLE, counter = 0, shreg = 0, word = 0, word_valid = 0, frame_err = 0, err_count = 0, busy = 0, timeout counter = TIMEOUT_CYCLES.
REQ-033 Reset asserted mid-frame SHALL discard the frame without asserting frame_err.
REQ-034 The first byte SHALL be accepted on the first rising clk edge after rst_n deasserts.

Verification
REQ-035 Bytes F5 DE AD BE EF FA -> word = 0xDEADBEEF, word_valid high one cycle after the FA strobe, frame_err never high, busy low afterwards.
REQ-036 Bytes 00 11 F5 12 34 56 78 FA -> leading bytes ignored, word = 0x12345678, err_count = 0.
REQ-037 Bytes F5 01 02 03 04 00 -> one frame_err pulse, err_count = 1, word unchanged; then F5 01 02 03 04 F5 05 06 07 08 FA -> err_count = 2, word = 0x05060708.
REQ-038 With TIMEOUT_CYCLES = 16: bytes F5 01 02, then no bytes for 16 cycles -> frame_err pulse, busy low; a following full frame decodes correctly.
REQ-039 Bytes F5 FA F5 FA F5 FA -> word = 0xFAF5FAF5, no error; a 300-frame error burst -> err_count held at 255.
REQ-040 rst_n pulsed low after F5 AA -> all outputs 0 immediately, no frame_err; then F5 00 00 00 01 FA -> word = 0x00000001.
